// File: rtl/mma_sequencer_if.sv
// mma_sequencer_if: DRAM read/write handshake bus between the sequencer (master) and memory (slave)
interface mma_sequencer_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 28
);
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_gnt;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_gnt;
    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_gnt, rd_valid, rd_data, wr_gnt
    );
    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_gnt, rd_valid, rd_data, wr_gnt
    );
endinterface

// File: rtl/mma_sequencer.sv
// mma_sequencer: streams A/B matrix words through an external adder into R; MMA_SEQUENCER_PERF_EN adds cycle_count
module mma_sequencer #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 28,
    parameter int A_BASE     = 0,
    parameter int B_BASE     = 65536,
    parameter int R_BASE     = 131072
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] mat_mem_len,
    mma_sequencer_if.master       mem,
    output logic [DATA_WIDTH-1:0] data_A,
    output logic [DATA_WIDTH-1:0] data_B,
    input  logic [DATA_WIDTH-1:0] data_sum,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] word_idx
`ifdef MMA_SEQUENCER_PERF_EN
    ,
    output logic [31:0]           cycle_count
`endif
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RD_A   = 3'd1;
    localparam logic [2:0] WAIT_A = 3'd2;
    localparam logic [2:0] RD_B   = 3'd3;
    localparam logic [2:0] WAIT_B = 3'd4;
    localparam logic [2:0] WR     = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;
    localparam logic [ADDR_WIDTH-1:0] a_base = ADDR_WIDTH'(A_BASE);
    localparam logic [ADDR_WIDTH-1:0] b_base = ADDR_WIDTH'(B_BASE);
    localparam logic [ADDR_WIDTH-1:0] r_base = ADDR_WIDTH'(R_BASE);
    logic [2:0]            state, nxt;
    logic [ADDR_WIDTH-1:0] idx, len;
    logic                  last, start_job;
    assign last      = idx == len - ADDR_WIDTH'(1);
    assign start_job = state == IDLE && start && !abort;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? (mat_mem_len == '0 ? DONE : RD_A) : IDLE;
            RD_A:    nxt = mem.rd_gnt ? WAIT_A : RD_A;
            WAIT_A:  nxt = mem.rd_valid ? RD_B : WAIT_A;
            RD_B:    nxt = mem.rd_gnt ? WAIT_B : RD_B;
            WAIT_B:  nxt = mem.rd_valid ? WR : WAIT_B;
            WR:      nxt = mem.wr_gnt ? (last ? DONE : RD_A) : WR;
            default: nxt = IDLE;
        endcase
        if (abort)
            nxt = IDLE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            idx    <= '0;
            len    <= '0;
            data_A <= '0;
            data_B <= '0;
            done   <= 1'b0;
        end else begin
            state <= nxt;
            done  <= state == DONE && !abort;
            if (start_job) begin
                len <= mat_mem_len;
                idx <= '0;
            end
            if (state == WR && mem.wr_gnt && !abort && !last)
                idx <= idx + ADDR_WIDTH'(1);
            if (state == WAIT_A && mem.rd_valid && !abort)
                data_A <= mem.rd_data;
            if (state == WAIT_B && mem.rd_valid && !abort)
                data_B <= mem.rd_data;
        end
    end
    // request outputs decode straight from state so an abort drops them on the very next cycle
    assign busy        = state != IDLE;
    assign word_idx    = idx;
    assign mem.rd_req  = state == RD_A || state == RD_B;
    assign mem.rd_addr = state == RD_A ? a_base + idx : state == RD_B ? b_base + idx : '0;
    assign mem.wr_req  = state == WR;
    assign mem.wr_addr = mem.wr_req ? r_base + idx : '0;
    assign mem.wr_data = mem.wr_req ? data_sum : '0;
`ifdef MMA_SEQUENCER_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cycle_count <= '0;
        else if (start_job)
            cycle_count <= '0;
        else if (busy && cycle_count != '1)
            cycle_count <= cycle_count + 32'd1;
    end
`endif
endmodule
